// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch-resolution frontend.
package bp_pkg;

    localparam int BP_GHR_BITS     = 8;
    localparam int BP_CKPT_DEPTH   = 8;
    // Checkpoint index/history fields are sized for the widest supported history.
    localparam int BP_MAX_GHR_BITS = 16;

    localparam logic [1:0] BP_CTR_RESET = 2'b01;   // weakly not-taken

    typedef enum logic {
        IDLE,
        REDIRECT
    } bp_state;

    typedef struct packed {
        logic [63:0]                pc;
        logic [BP_MAX_GHR_BITS-1:0] idx;
        logic [BP_MAX_GHR_BITS-1:0] ghr_before;
        logic                       pred_taken;
    } ckpt_entry;

    // Saturating 2-bit counter step towards taken (up=1) or not-taken.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic up);
        if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// In-order checkpoint FIFO of outstanding predictions; flush beats push.
module ghr_ckpt_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_CKPT_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ckpt_entry push_data,
    input  logic      pop,
    input  logic      flush,
    output ckpt_entry head_data,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0] head_ptr;
    logic [AW:0] tail_ptr;
    ckpt_entry   mem [DEPTH];

    assign empty     = (head_ptr == tail_ptr);
    assign full      = (head_ptr[AW] != tail_ptr[AW]) &&
                       (head_ptr[AW-1:0] == tail_ptr[AW-1:0]);
    assign head_data = mem[head_ptr[AW-1:0]];

    // Pointer update: flush discards everything outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (flush) begin
            head_ptr <= tail_ptr;
        end else begin
            if (push && !full)  tail_ptr <= tail_ptr + 1'b1;
            if (pop  && !empty) head_ptr <= head_ptr + 1'b1;
        end
    end

    // Storage write at the tail; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem[tail_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bp_resolve_unit.sv
// Gshare predictor with in-order checkpoints, resolution training and redirect.
module bp_resolve_unit
    import bp_pkg::*;
#(
    parameter int GHR_BITS   = BP_GHR_BITS,     // up to BP_MAX_GHR_BITS
    parameter int CKPT_DEPTH = BP_CKPT_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_N_in,
    input  logic        pred_valid_in,
    input  logic [63:0] pred_pc_in,
    output logic        pred_ready_out,
    output logic        pred_taken_out,
    input  logic        bcond_resolved_in,
    input  logic        pc_incorrect_in,
    input  logic        taken_in,
    input  logic [63:0] pc_in,
    input  logic [18:0] correction_offset_in,
    output logic        redirect_valid_out,
    output logic [63:0] redirect_pc_out,
    input  logic        redirect_ready_in,
    output logic        err_out
);

    localparam int PHT_SIZE = 1 << GHR_BITS;

    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] idx;
    logic [1:0]          pht [PHT_SIZE];
    bp_state             state;

    ckpt_entry           push_entry;
    ckpt_entry           head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                resolve;
    logic                mispredict;
    logic [GHR_BITS-1:0] head_idx;
    logic [GHR_BITS-1:0] head_ghr;
    logic [63:0]         offset_bytes;
    logic [63:0]         redirect_target;
    logic                unused_ckpt;

    assign idx            = pred_pc_in[GHR_BITS+1:2] ^ ghr;
    assign pred_taken_out = pht[idx][1];
    // A mispredict on the input blocks the push so it can't land after the flush.
    assign pred_ready_out = !fifo_full && (state == IDLE) &&
                            !(bcond_resolved_in && pc_incorrect_in);
    assign push           = pred_valid_in && pred_ready_out;
    // A resolve with nothing outstanding is a protocol error and changes nothing.
    assign resolve        = bcond_resolved_in && !fifo_empty;
    assign mispredict     = resolve && pc_incorrect_in;

    assign head_idx       = head.idx[GHR_BITS-1:0];
    assign head_ghr       = head.ghr_before[GHR_BITS-1:0];
    assign unused_ckpt    = ^{head.pred_taken, head.idx, head.ghr_before};

    // Word offset to byte offset, sign-extended to 64 bits.
    assign offset_bytes    = {{43{correction_offset_in[18]}}, correction_offset_in, 2'b00};
    assign redirect_target = taken_in ? pc_in + offset_bytes : pc_in + 64'd4;

    // Build the checkpoint for the branch being predicted this cycle.
    always_comb begin
        push_entry                         = '0;
        push_entry.pc                      = pred_pc_in;
        push_entry.idx[GHR_BITS-1:0]        = idx;
        push_entry.ghr_before[GHR_BITS-1:0] = ghr;
        push_entry.pred_taken              = pred_taken_out;
    end

    ghr_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_N_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (resolve),
        .flush     (mispredict),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Speculative history: shift in each prediction, repair from checkpoint on mispredict.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in)       ghr <= '0;
        else if (mispredict) ghr <= {head_ghr[GHR_BITS-2:0], taken_in};
        else if (push)       ghr <= {ghr[GHR_BITS-2:0], pred_taken_out};
    end

    // Train the counter recorded at prediction time with the actual direction.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= BP_CTR_RESET;
        end else if (resolve) begin
            pht[head_idx] <= ctr_update(pht[head_idx], taken_in);
        end
    end

    // Sticky error: resolve with nothing outstanding, or PC out of order.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in)
            err_out <= 1'b0;
        else if (bcond_resolved_in && (fifo_empty || head.pc != pc_in))
            err_out <= 1'b1;
    end

    // Redirect handshake with registered outputs; PC held until fetch accepts.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state              <= IDLE;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
        end else begin
            case (state)
                IDLE: if (mispredict) begin
                    state              <= REDIRECT;
                    redirect_valid_out <= 1'b1;
                    redirect_pc_out    <= redirect_target;
                end
                REDIRECT: if (redirect_ready_in) begin
                    state              <= IDLE;
                    redirect_valid_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Directed bench for bp_resolve_unit with a redirect-PC scoreboard.
module tb_bp_resolve_unit;

    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        pred_valid_in;
    logic [63:0] pred_pc_in;
    logic        pred_ready_out;
    logic        pred_taken_out;
    logic        bcond_resolved_in;
    logic        pc_incorrect_in;
    logic        taken_in;
    logic [63:0] pc_in;
    logic [18:0] correction_offset_in;
    logic        redirect_valid_out;
    logic [63:0] redirect_pc_out;
    logic        redirect_ready_in;
    logic        err_out;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    bp_resolve_unit dut (
        .clk_in               (clk_in),
        .rst_N_in             (rst_N_in),
        .pred_valid_in        (pred_valid_in),
        .pred_pc_in           (pred_pc_in),
        .pred_ready_out       (pred_ready_out),
        .pred_taken_out       (pred_taken_out),
        .bcond_resolved_in    (bcond_resolved_in),
        .pc_incorrect_in      (pc_incorrect_in),
        .taken_in             (taken_in),
        .pc_in                (pc_in),
        .correction_offset_in (correction_offset_in),
        .redirect_valid_out   (redirect_valid_out),
        .redirect_pc_out      (redirect_pc_out),
        .redirect_ready_in    (redirect_ready_in),
        .err_out              (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        pred_valid_in        = 1'b0;
        bcond_resolved_in    = 1'b0;
        pc_incorrect_in      = 1'b0;
        taken_in             = 1'b0;
        pc_in                = '0;
        correction_offset_in = '0;
        redirect_ready_in    = 1'b0;
    endtask

    // Present a branch, check its prediction and acceptance, let it push.
    task automatic push_chk(input logic [63:0] pc, input logic exp_pred, input string tag);
        pred_pc_in    = pc;
        pred_valid_in = 1'b1;
        #1;
        chk({tag, "_pred"}, pred_taken_out, exp_pred);
        chk({tag, "_rdy"},  pred_ready_out, 1'b1);
        @(negedge clk_in);
        pred_valid_in = 1'b0;
    endtask

    task automatic resolve(input logic [63:0] pc, input logic tk, input logic bad,
                           input logic [18:0] off);
        bcond_resolved_in    = 1'b1;
        pc_in                = pc;
        taken_in             = tk;
        pc_incorrect_in      = bad;
        correction_offset_in = off;
        @(negedge clk_in);
        bcond_resolved_in = 1'b0;
        pc_incorrect_in   = 1'b0;
        taken_in          = 1'b0;
    endtask

    // Redirect must be up the cycle after the mispredicted resolve.
    task automatic check_redirect(input string tag);
        logic [63:0] exp_pc;
        chk({tag, "_rv"}, redirect_valid_out, 1'b1);
        if (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            chk({tag, "_rpc"}, redirect_pc_out, exp_pc);
        end else begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=redirect expected=none_queued", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        pred_pc_in = 64'h1000;
        rst_N_in   = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        chk("rst_pred", pred_taken_out, 1'b0);
        chk("rst_rdy",  pred_ready_out, 1'b1);
        chk("rst_rv",   redirect_valid_out, 1'b0);
        chk("rst_rpc",  redirect_pc_out, 64'h0);
        chk("rst_err",  err_out, 1'b0);

        // Training: counter at entry 0 goes 01 -> 10 -> 11 -> 11.
        push_chk(64'h1000, 1'b0, "tr1");
        resolve(64'h1000, 1'b1, 1'b0, 19'h0);
        push_chk(64'h1000, 1'b1, "tr2");
        resolve(64'h1000, 1'b1, 1'b0, 19'h0);
        push_chk(64'h1004, 1'b1, "tr3");          // ghr=1, idx=1^1=0
        resolve(64'h1004, 1'b1, 1'b0, 19'h0);
        pred_pc_in = 64'h100C;                    // ghr=3, idx=3^3=0
        #1;
        chk("tr4_pred", pred_taken_out, 1'b1);
        chk("tr_err", err_out, 1'b0);

        // Mispredict taken with offset -4 words.
        push_chk(64'h2000, 1'b0, "mp_a");         // idx 3, ghr_before=3
        push_chk(64'h2004, 1'b0, "mp_b");
        exp_q.push_back(64'h1FF0);
        pred_pc_in           = 64'h2008;
        pred_valid_in        = 1'b1;
        bcond_resolved_in    = 1'b1;
        pc_in                = 64'h2000;
        taken_in             = 1'b1;
        pc_incorrect_in      = 1'b1;
        correction_offset_in = 19'h7FFFC;
        #1;
        chk("mp_same_rdy", pred_ready_out, 1'b0);
        @(negedge clk_in);
        bcond_resolved_in = 1'b0;
        pc_incorrect_in   = 1'b0;
        taken_in          = 1'b0;
        check_redirect("mp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("mp_hold_rv",  redirect_valid_out, 1'b1);
            chk("mp_hold_rpc", redirect_pc_out, 64'h1FF0);
            chk("mp_hold_rdy", pred_ready_out, 1'b0);
        end
        pred_valid_in     = 1'b0;
        redirect_ready_in = 1'b1;
        @(negedge clk_in);
        redirect_ready_in = 1'b0;
        chk("mp_rel_rv",  redirect_valid_out, 1'b0);
        chk("mp_rel_rdy", pred_ready_out, 1'b1);
        pred_pc_in = 64'h2010;                    // ghr=7, idx=4^7=3, counter now 10
        #1;
        chk("mp_ghr_pred", pred_taken_out, 1'b1);

        // Resolve on an empty FIFO: error only, no redirect.
        resolve(64'h2004, 1'b1, 1'b1, 19'h0);
        chk("empty_err", err_out, 1'b1);
        chk("empty_rv",  redirect_valid_out, 1'b0);
        @(negedge clk_in);
        chk("empty_err_sticky", err_out, 1'b1);
        chk("empty_rv2", redirect_valid_out, 1'b0);

        rst_N_in = 1'b0;
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        chk("rst2_err", err_out, 1'b0);

        // Full FIFO: eight pushes, then a pop frees one slot for the ninth.
        for (int i = 0; i < 8; i++) push_chk(64'h4000 + 64'(4 * i), 1'b0, "ff");
        pred_pc_in    = 64'h5000;
        pred_valid_in = 1'b1;
        #1;
        chk("ff_full_rdy", pred_ready_out, 1'b0);
        bcond_resolved_in = 1'b1;
        pc_in             = 64'h4000;
        #1;
        chk("ff_pop_rdy", pred_ready_out, 1'b0);
        @(negedge clk_in);
        bcond_resolved_in = 1'b0;
        #1;
        chk("ff_back_rdy",  pred_ready_out, 1'b1);
        chk("ff_back_pred", pred_taken_out, 1'b0);
        @(negedge clk_in);
        pred_valid_in = 1'b0;
        #1;
        chk("ff_refull_rdy", pred_ready_out, 1'b0);
        for (int i = 1; i < 8; i++) resolve(64'h4000 + 64'(4 * i), 1'b0, 1'b0, 19'h0);
        resolve(64'h5000, 1'b0, 1'b0, 19'h0);
        chk("ff_order_err", err_out, 1'b0);
        chk("ff_drain_rdy", pred_ready_out, 1'b1);

        // PC mismatch: error raised but entry 1 still trained 00 -> 01 -> 10.
        push_chk(64'h3004, 1'b0, "pm1");
        resolve(64'h3000, 1'b1, 1'b0, 19'h0);
        chk("pm_err", err_out, 1'b1);
        push_chk(64'h3004, 1'b0, "pm2");
        resolve(64'h3000, 1'b1, 1'b0, 19'h0);
        pred_pc_in = 64'h3004;
        #1;
        chk("pm_trained_pred", pred_taken_out, 1'b1);

        // Not-taken mispredict, then reset while the redirect is pending.
        push_chk(64'h6000, 1'b0, "rr");
        exp_q.push_back(64'h6004);
        resolve(64'h6000, 1'b0, 1'b1, 19'h0);
        check_redirect("rr");
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("rr_rv",  redirect_valid_out, 1'b0);
        chk("rr_rpc", redirect_pc_out, 64'h0);
        chk("rr_err", err_out, 1'b0);
        chk("rr_rdy", pred_ready_out, 1'b1);
        pred_pc_in = 64'h3004;
        #1;
        chk("rr_pht_pred", pred_taken_out, 1'b0);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        @(negedge clk_in);
        chk("rr_after_rv", redirect_valid_out, 1'b0);
        resolve(64'h6000, 1'b0, 1'b0, 19'h0);     // FIFO must be empty after reset
        chk("rr_fifo_empty_err", err_out, 1'b1);
        chk("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
